// File: rtl/word_packer.sv
// Packs RATIO narrow input beats into one wide output word.
// in_last closes a partial word early; unwritten lanes read as zero.
module word_packer #(
    parameter int IN_W      = 1,
    parameter int RATIO     = 2,
    parameter bit MSB_FIRST = 1'b1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    input  logic             out_ready
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   odata_q, odata_d;
    logic [CNT_W-1:0]   ocount_q, ocount_d;
    logic               olast_q, olast_d;
    logic [CNT_W-1:0]   lane;
    logic [OUT_W-1:0]   acc_wb;
    logic               take;
    logic               close;

    assign in_ready  = (state_q == FILL) || out_ready;
    assign take      = in_valid && in_ready;
    assign close     = take && (in_last || (idx_q == LAST_IDX));
    assign out_valid = (state_q == HOLD);
    assign out_data  = odata_q;
    assign out_count = ocount_q;
    assign out_last  = olast_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        odata_d  = odata_q;
        ocount_d = ocount_q;
        olast_d  = olast_q;
        lane     = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
        acc_wb   = acc_q;
        acc_wb[int'(lane)*IN_W +: IN_W] = in_data;

        // idx is already 0 in HOLD, so a beat taken during handover starts the next word
        if (close) begin
            state_d  = HOLD;
            idx_d    = '0;
            acc_d    = '0;
            odata_d  = acc_wb;
            ocount_d = idx_q + CNT_W'(1);
            olast_d  = in_last;
        end else if (take) begin
            state_d = FILL;
            idx_d   = idx_q + CNT_W'(1);
            acc_d   = acc_wb;
        end else if (state_q == HOLD && out_ready) begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILL;
            idx_q    <= '0;
            acc_q    <= '0;
            odata_q  <= '0;
            ocount_q <= '0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            odata_q  <= odata_d;
            ocount_q <= ocount_d;
            olast_q  <= olast_d;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: default, wide LSB-first and RATIO=1
// configurations, driven on the falling edge and sampled before the rising one.
module tb_word_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // default: IN_W=1 RATIO=2 MSB_FIRST=1
    logic       a_v, a_d, a_l, a_rdy, a_ir, a_ov, a_ol;
    logic [1:0] a_od, a_oc;
    word_packer u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_v), .in_data(a_d), .in_last(a_l), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_count(a_oc),
        .out_last(a_ol), .out_ready(a_rdy)
    );

    // IN_W=8 RATIO=4 MSB_FIRST=0
    logic        b_v, b_l, b_rdy, b_ir, b_ov, b_ol;
    logic [7:0]  b_d;
    logic [31:0] b_od;
    logic [2:0]  b_oc;
    word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_v), .in_data(b_d), .in_last(b_l), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_count(b_oc),
        .out_last(b_ol), .out_ready(b_rdy)
    );

    // IN_W=4 RATIO=1
    logic       c_v, c_l, c_rdy, c_ir, c_ov, c_ol;
    logic [3:0] c_d, c_od;
    logic [0:0] c_oc;
    word_packer #(.IN_W(4), .RATIO(1)) u_c (
        .clk(clk), .reset(reset),
        .in_valid(c_v), .in_data(c_d), .in_last(c_l), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_count(c_oc),
        .out_last(c_ol), .out_ready(c_rdy)
    );

    typedef struct {
        logic       v, d, l, rdy;
        logic       e_ir, e_ov;
        logic [1:0] e_od, e_oc;
        logic       e_ol;
    } vec_t;

    function automatic vec_t mk(logic v, logic d, logic l, logic rdy,
                                logic ir, logic ov, logic [1:0] od,
                                logic [1:0] oc, logic ol);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.rdy = rdy;
        t.e_ir = ir; t.e_ov = ov; t.e_od = od; t.e_oc = oc; t.e_ol = ol;
        return t;
    endfunction

    vec_t tv[18];
    int   words;

    initial begin
        tv[0]  = mk(1, 1, 0, 1,  1, 0, 2'b00, 2'd0, 0);
        tv[1]  = mk(1, 0, 0, 1,  1, 0, 2'b00, 2'd0, 0);
        tv[2]  = mk(0, 1, 0, 1,  1, 1, 2'b10, 2'd2, 0);
        tv[3]  = mk(0, 1, 0, 1,  1, 0, 2'b10, 2'd2, 0);
        tv[4]  = mk(1, 1, 1, 1,  1, 0, 2'b10, 2'd2, 0);
        tv[5]  = mk(1, 0, 0, 1,  1, 1, 2'b10, 2'd1, 1);
        tv[6]  = mk(1, 1, 0, 1,  1, 0, 2'b10, 2'd1, 1);
        tv[7]  = mk(0, 0, 0, 0,  0, 1, 2'b01, 2'd2, 0);
        tv[8]  = mk(1, 1, 0, 1,  1, 1, 2'b01, 2'd2, 0);
        tv[9]  = mk(1, 1, 0, 0,  1, 0, 2'b01, 2'd2, 0);
        for (int i = 10; i < 15; i++)
            tv[i] = mk(1, i[0], 0, 0,  0, 1, 2'b11, 2'd2, 0);
        tv[15] = mk(1, 0, 1, 1,  1, 1, 2'b11, 2'd2, 0);
        tv[16] = mk(0, 0, 0, 1,  1, 1, 2'b00, 2'd1, 1);
        tv[17] = mk(0, 0, 0, 1,  1, 0, 2'b00, 2'd1, 1);

        reset = 1'b1;
        a_v = 0; a_d = 0; a_l = 0; a_rdy = 0;
        b_v = 0; b_d = 0; b_l = 0; b_rdy = 1;
        c_v = 0; c_d = 0; c_l = 0; c_rdy = 1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            a_v = tv[i].v; a_d = tv[i].d; a_l = tv[i].l; a_rdy = tv[i].rdy;
            #1;
            chk($sformatf("a_ir[%0d]", i), 64'(a_ir), 64'(tv[i].e_ir));
            chk($sformatf("a_ov[%0d]", i), 64'(a_ov), 64'(tv[i].e_ov));
            chk($sformatf("a_od[%0d]", i), 64'(a_od), 64'(tv[i].e_od));
            chk($sformatf("a_oc[%0d]", i), 64'(a_oc), 64'(tv[i].e_oc));
            chk($sformatf("a_ol[%0d]", i), 64'(a_ol), 64'(tv[i].e_ol));
            @(negedge clk);
        end

        // reset mid-word discards the partial beat
        a_v = 1; a_d = 1; a_l = 0; a_rdy = 1;
        @(negedge clk);
        a_v = 0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ir", 64'(a_ir), 64'd1);
        chk("rst_ov", 64'(a_ov), 64'd0);
        chk("rst_oc", 64'(a_oc), 64'd0);
        chk("rst_ol", 64'(a_ol), 64'd0);
        a_v = 1; a_d = 0;
        @(negedge clk);
        #1;
        chk("rst_nobeat_ov", 64'(a_ov), 64'd0);
        @(negedge clk);
        a_v = 0;
        #1;
        chk("rst_w_ov", 64'(a_ov), 64'd1);
        chk("rst_w_od", 64'(a_od), 64'd0);
        chk("rst_w_oc", 64'(a_oc), 64'd2);
        chk("rst_w_ol", 64'(a_ol), 64'd0);
        @(negedge clk);

        // reset during HOLD drops the held word
        a_v = 1; a_d = 1; a_rdy = 0;
        repeat (2) @(negedge clk);
        a_v = 0;
        #1;
        chk("hold_ov", 64'(a_ov), 64'd1);
        chk("hold_od", 64'(a_od), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("hrst_ov", 64'(a_ov), 64'd0);
        chk("hrst_od", 64'(a_od), 64'd0);
        chk("hrst_oc", 64'(a_oc), 64'd0);
        chk("hrst_ir", 64'(a_ir), 64'd1);

        // wide LSB-first full word then a partial word
        for (int i = 0; i < 4; i++) begin
            b_v = 1; b_d = 8'((i + 1) * 8'h11);
            #1;
            chk($sformatf("b_ov_fill[%0d]", i), 64'(b_ov), 64'd0);
            @(negedge clk);
        end
        b_v = 0;
        #1;
        chk("b_full_ov", 64'(b_ov), 64'd1);
        chk("b_full_od", 64'(b_od), 64'h44332211);
        chk("b_full_oc", 64'(b_oc), 64'd4);
        chk("b_full_ol", 64'(b_ol), 64'd0);
        @(negedge clk);
        #1;
        chk("b_drop_ov", 64'(b_ov), 64'd0);
        b_v = 1; b_d = 8'hAA; b_l = 0;
        @(negedge clk);
        b_d = 8'hBB; b_l = 1;
        @(negedge clk);
        b_v = 0; b_l = 0;
        #1;
        chk("b_part_ov", 64'(b_ov), 64'd1);
        chk("b_part_od", 64'(b_od), 64'h0000BBAA);
        chk("b_part_oc", 64'(b_oc), 64'd2);
        chk("b_part_ol", 64'(b_ol), 64'd1);
        @(negedge clk);

        // RATIO=1 streams one word per cycle
        words = 0;
        for (int i = 0; i < 8; i++) begin
            c_v = 1; c_d = 4'(i + 1);
            #1;
            chk($sformatf("c_ir[%0d]", i), 64'(c_ir), 64'd1);
            if (i > 0 && c_ov && c_od == 4'(i) && c_oc == 1'b1) words++;
            @(negedge clk);
        end
        c_v = 0;
        #1;
        if (c_ov && c_od == 4'd8 && c_oc == 1'b1) words++;
        chk("c_words", 64'(words), 64'd8);
        @(negedge clk);
        #1;
        chk("c_idle_ov", 64'(c_ov), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 Parameter IN_W, default 1: width of one input beat in bits, legal range 1..64.
REQ-002 Parameter RATIO, default 2: number of input beats per output word, legal range 1..16.
REQ-003 Parameter MSB_FIRST, default 1: 1 places the first beat in the most-significant lane, as {first,second}; 0 places it in the least-significant lane.
REQ-004 Derived OUT_W = IN_W*RATIO and CNT_W = $clog2(RATIO+1), both local, not overridable.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_data  input  IN_W  input beat payload.
REQ-009 in_last  input  1  beat closes the current word even if it is not yet full.
REQ-010 in_ready  output  1  packer accepts a beat this cycle.
REQ-011 out_valid  output  1  packed word present.
REQ-012 out_data  output  OUT_W  packed word.
REQ-013 out_count  output  CNT_W  number of valid beats in out_data, 1..RATIO.
REQ-014 out_last  output  1  word was closed by in_last.
REQ-015 out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-016 Input handshake: a beat is taken when in_valid && in_ready at the rising edge; output handshake: out_valid && out_ready.
REQ-017 States FILL (accumulating, out_valid=0) and HOLD (word presented, out_valid=1).
REQ-018 in_ready = (state==FILL) || (state==HOLD && out_ready), combinational, with no dependence on in_valid.
REQ-019 FILL: each accepted beat is written to lane idx and idx increments; the lane is idx when MSB_FIRST=0, RATIO-1-idx when MSB_FIRST=1.
REQ-020 FILL -> HOLD on the edge that accepts beat RATIO-1 or any beat with in_last=1.
REQ-021 At the HOLD transition: out_data = accumulator including that beat, out_count = beats in the word, out_last = in_last of the closing beat, idx reset to 0.
REQ-022 Latency: out_valid rises exactly 1 cycle after the closing input handshake.
REQ-023 Lanes never written in a partial word SHALL read 0; the accumulator clears to 0 when each word closes.
REQ-024 HOLD with out_ready=0: out_data, out_count and out_last stay stable, and no beat is accepted.
REQ-025 HOLD with out_ready=1 and no input beat: next state FILL, out_valid=0.
REQ-026 HOLD with out_ready=1 and an accepted beat in the same cycle: that beat becomes lane-0-index beat of the next word.
REQ-027 In the REQ-026 case, if that beat itself closes a word (RATIO=1 or in_last=1), the state stays HOLD and presents the new word next cycle with no bubble.
REQ-028 RATIO=1: every beat is a full word, out_count=1, and sustained throughput is 1 word/cycle when out_ready=1.
REQ-029 in_last on the first beat of a word gives out_count=1.
REQ-030 in_data is ignored when no input handshake occurs, and out_data changes only on a HOLD transition.

Reset
REQ-031 While reset=1 at a rising edge: state=FILL, idx=0, accumulator=0, out_valid=0, out_data=0, out_count=0, out_last=0.
REQ-032 Reset mid-word or during HOLD discards the partial or held word without emitting it.
REQ-033 in_ready=1 in the first cycle after reset deasserts.

Verification (IN_W=1, RATIO=2, MSB_FIRST=1 unless stated)
REQ-034 Beats 1,0 with out_ready=1 -> out_data=2'b10, out_count=2, out_last=0, out_valid high for exactly one cycle, one cycle after beat 2.
REQ-035 Beat 1 with in_last=1 -> out_data=2'b10, out_count=1, out_last=1; then beats 0,1 -> 2'b01, out_count=2.
REQ-036 Word 2'b11 held with out_ready=0 for 5 cycles -> in_ready=0 and out_data stable throughout; raising out_ready with in_valid=1 hands over the word and accepts the next beat in the same cycle.
REQ-037 IN_W=8, RATIO=4, MSB_FIRST=0, beats 0x11,0x22,0x33,0x44 -> out_data=32'h44332211.
REQ-038 Assert reset after one beat of 1 -> no word emitted; the next beats 0,0 give out_data=2'b00, out_count=2.
REQ-039 RATIO=1, in_valid=1 and out_ready=1 held for 8 cycles -> 8 words on consecutive cycles.
